rr_arb8_ctl: RTL and testbench
==============================

# rr_arb8_ctl

Round-robin arbiter and sequencer for the shared 8-bit, 8-input channel built on `mux81_8b`. Eight requesters each present a byte and a request line. The block grants one requester at a time and drives the mux select and enable. It streams up to `MAX_BURST` beats per grant to a single downstream consumer under a valid/ready handshake, then rotates ownership fairly.

## Interface
Parameters:
- `MAX_BURST`, default 4: beats per grant before forced rotation; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request per requester; bit i pairs with `ci`.
- `c0`..`c7`  in  8 each  requester data bytes, routed to `mux81_8b`.
- `ready`  in  1  downstream accepts a beat this cycle.
- `d`  out  8  selected byte, i.e. the mux output.
- `valid`  out  1  `d` is a live beat.
- `gnt`  out  8  one-hot grant, registered.
- `a`  out  3  binary index of the owner; drives the mux select.
- `busy`  out  1  a grant is held; drives the mux `en`.

Reset: one clock; reset is asynchronous and active-high.

## Operation
- State `IDLE` with `req==0`: the block stays in `IDLE`.
- State `IDLE` with `req!=0`: pick the first set bit scanning `ptr, ptr+1, … ptr+7` (mod 8). Load `gnt`, `a`, and `cnt=0`, then go to `GRANT`.
- `GRANT`:
  - `valid = busy & req[a]`.
  - A beat occurs when `valid & ready`; each beat increments `cnt`.
- Release condition: either `req[a]==0`, or a beat with `cnt==MAX_BURST-1`.
- On release:
  - `ptr <= a+1` (3-bit wrap, 7→0).
  - Re-arbitrate in the same cycle over current `req`, scanning from `a+1`. The current owner is considered last, so a lone requester is re-granted with `cnt=0`.
  - If no request remains, go to `IDLE`.
- Stall: `ready=0` holds `cnt`, `gnt` and `a` indefinitely while `req[a]` stays high.
- Requests must stay high until their beats complete. A drop ends the grant with no partial-beat semantics.
- `d`:
  - Equals `c[a]` while `busy`.
  - Is 8'h00 when `busy==0`.
  - Is not registered.
- Invariants: `gnt` is one-hot or zero, and `gnt==(busy ? 1<<a : 0)`.

## Timing
- Reset values: state `IDLE`, `gnt=0`, `a=0`, `busy=0`, `valid=0`, `d=0`, `ptr=0`, `cnt=0`. Outputs clear immediately on `rst` assertion, without waiting for a clock edge.
- Grant latency: `req` sampled high at edge N gives `gnt`/`busy` high after edge N, so the first `valid` appears in cycle N+1.
- Handoff on release: the new `gnt` is valid after the next edge. There is no idle bubble when other requests are pending.
- Throughput: with `ready` held high, one beat per cycle, except the single arbitration cycle from `IDLE`.
- Simultaneous events:
  - Release coinciding with a new request: the new request competes in that cycle's scan.
  - Last beat coinciding with `req[a]` dropping: treated as a normal release.
- `rst` deasserted mid-burst: arbitration restarts from `ptr=0`, and no beat is replayed.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding (`IDLE=1'b0`, `GRANT=1'b1`),
  - `N_REQ=8`,
  - `IDX_W=3`,
  - the default `MAX_BURST`.
- Instantiate one `mux81_8b` sub-module:
  - `c0..c7` straight through,
  - `a` to `a`,
  - `en` to `busy`,
  - `d` to `d`.
- A rotating priority encoder is a function inside the block, not a separate module.

## Test plan
- Reset check: assert `rst` with random `req` → `gnt=0`, `a=0`, `busy=0`, `valid=0`, `d=8'h00`.
- Single requester: `req=8'h08`, `ready=1`, `MAX_BURST=4`, `c3=8'h5A` →
  - `gnt=8'h08` one cycle after `req`,
  - `a=3`, `d=8'h5A`,
  - `valid` continuous; re-grant to 3 every 4 beats with no gap.
- Fairness: `req=8'hFF`, `ready=1` → owners 0,1,2,…,7,0, each holding exactly 4 beats, with handoffs on consecutive cycles.
- Stall: `req=8'h02`, `ready=0` for 10 cycles then 1 →
  - `gnt=8'h02` held throughout,
  - `cnt` frozen during the stall,
  - then 4 beats before re-grant.
- Early drop: owner 2 with `req[5]` pending; `req[2]` drops after 2 beats → `gnt=8'h20` on the next edge, and `ptr` advances past 2.
- Reset mid-burst: pulse `rst` during owner-6 beat 2 → `gnt`/`valid` are 0 immediately; after release with `req=8'h41`, the first grant goes to 0.

Source files
------------

// File: rtl/rr_arb8_ctl_pkg.sv
// Shared definitions for the 8-input round-robin arbiter: state encoding,
// sizing constants and the debug view of the controller's internal state.
package arb_pkg;

    localparam int N_REQ             = 8;
    localparam int IDX_W             = 3;
    localparam int MAX_BURST_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        state_e           state;
        logic [IDX_W-1:0] ptr;
        logic [3:0]       cnt;
    } dbg_t;

endpackage

// File: rtl/rr_arb8_ctl_if.sv
// Requester/consumer bundle of the shared channel. The arbiter is the slave;
// the requesters plus the downstream consumer together form the master side.
interface rr_arb8_ctl_if;
    import arb_pkg::*;

    // valid/ready: a beat transfers on a cycle where valid and ready are both high;
    // valid never waits on ready, and d is stable whenever valid is high.
    logic [N_REQ-1:0] req;
    logic [7:0]       c0, c1, c2, c3, c4, c5, c6, c7;
    logic             ready;
    logic [7:0]       d;
    logic             valid;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] a;
    logic             busy;
    dbg_t             dbg;

    modport slave (
        input  req, c0, c1, c2, c3, c4, c5, c6, c7, ready,
        output d, valid, gnt, a, busy, dbg
    );

    modport master (
        output req, c0, c1, c2, c3, c4, c5, c6, c7, ready,
        input  d, valid, gnt, a, busy, dbg
    );

endinterface

// File: rtl/mux81_8b.sv
// 8-to-1 byte multiplexer with enable; output is forced to zero when disabled.
module mux81_8b (
    input  logic [7:0] c0,
    input  logic [7:0] c1,
    input  logic [7:0] c2,
    input  logic [7:0] c3,
    input  logic [7:0] c4,
    input  logic [7:0] c5,
    input  logic [7:0] c6,
    input  logic [7:0] c7,
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] d
);

    always_comb begin
        d = 8'h00;
        if (en) begin
            case (a)
                3'd0: d = c0;
                3'd1: d = c1;
                3'd2: d = c2;
                3'd3: d = c3;
                3'd4: d = c4;
                3'd5: d = c5;
                3'd6: d = c6;
                default: d = c7;
            endcase
        end
    end

endmodule

// File: rtl/rr_arb8_ctl.sv
// Round-robin arbiter and burst sequencer for the shared 8-input byte channel.
// Grants one requester at a time, streams up to MAX_BURST beats, then rotates.
module rr_arb8_ctl
    import arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    rr_arb8_ctl_if.slave bus
);

    state_e           state, state_n;
    logic [IDX_W-1:0] a, a_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [3:0]       cnt, cnt_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [IDX_W:0]   pick;
    logic             busy, valid, beat, last_beat;

    // Returns {found, index} of the first set request scanning start, start+1, ... (mod 8).
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + IDX_W'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign busy      = (state == GRANT);
    assign valid     = busy & bus.req[a];
    assign beat      = valid & bus.ready;
    assign last_beat = (cnt == 4'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        pick    = '0;
        case (state)
            IDLE: begin
                pick = rr_pick(bus.req, ptr);
                if (pick[IDX_W]) begin
                    state_n = GRANT;
                    a_n     = pick[IDX_W-1:0];
                    gnt_n   = N_REQ'(1) << pick[IDX_W-1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!bus.req[a] || (beat && last_beat)) begin
                    // Scanning from a+1 puts the current owner last, so it only
                    // regains the channel when nobody else is asking.
                    ptr_n = a + IDX_W'(1);
                    pick  = rr_pick(bus.req, a + IDX_W'(1));
                    cnt_n = '0;
                    if (pick[IDX_W]) begin
                        a_n   = pick[IDX_W-1:0];
                        gnt_n = N_REQ'(1) << pick[IDX_W-1:0];
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (beat) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mux81_8b u_mux (
        .c0 (bus.c0),
        .c1 (bus.c1),
        .c2 (bus.c2),
        .c3 (bus.c3),
        .c4 (bus.c4),
        .c5 (bus.c5),
        .c6 (bus.c6),
        .c7 (bus.c7),
        .a  (a),
        .en (busy),
        .d  (bus.d)
    );

    assign bus.valid     = valid;
    assign bus.gnt       = gnt;
    assign bus.a         = a;
    assign bus.busy      = busy;
    assign bus.dbg.state = state;
    assign bus.dbg.ptr   = ptr;
    assign bus.dbg.cnt   = cnt;

endmodule

// File: tb/tb_rr_arb8_ctl.sv
// Directed bench for rr_arb8_ctl: reset, single requester, fairness, stall,
// early drop and reset mid-burst, all against hand-computed expectations.
module tb_rr_arb8_ctl;
    import arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cval [8];

    rr_arb8_ctl_if bus ();

    rr_arb8_ctl #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cval = '{'hA0, 'hB1, 'hC2, 'h5A, 'hE4, 'hF5, 'h06, 'h17};
        bus.c0 = 8'hA0; bus.c1 = 8'hB1; bus.c2 = 8'hC2; bus.c3 = 8'h5A;
        bus.c4 = 8'hE4; bus.c5 = 8'hF5; bus.c6 = 8'h06; bus.c7 = 8'h17;
        bus.ready = 1'b0;
        bus.req   = 8'($urandom_range(1, 255));
        rst       = 1'b1;

        // Reset with random requests pending
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt",   32'(bus.gnt),       'h00);
        check("rst_a",     32'(bus.a),         0);
        check("rst_busy",  32'(bus.busy),      0);
        check("rst_valid", 32'(bus.valid),     0);
        check("rst_d",     32'(bus.d),         'h00);
        check("rst_state", 32'(bus.dbg.state), 32'(IDLE));
        check("rst_ptr",   32'(bus.dbg.ptr),   0);
        check("rst_cnt",   32'(bus.dbg.cnt),   0);

        // Single requester 3, continuous ready: re-grant every 4 beats, no gap
        do_reset();
        bus.req   = 8'h08;
        bus.ready = 1'b1;
        #1;
        check("single_pre_busy",  32'(bus.busy),  0);
        check("single_pre_valid", 32'(bus.valid), 0);
        check("single_pre_d",     32'(bus.d),     'h00);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            check("single_gnt",   32'(bus.gnt),     'h08);
            check("single_a",     32'(bus.a),       3);
            check("single_d",     32'(bus.d),       'h5A);
            check("single_valid", 32'(bus.valid),   1);
            check("single_cnt",   32'(bus.dbg.cnt), k % 4);
        end
        @(negedge clk);
        bus.req = 8'h00;
        #1;
        check("single_drop_valid", 32'(bus.valid), 0);
        @(negedge clk);
        #1;
        check("single_idle_busy", 32'(bus.busy),    0);
        check("single_idle_gnt",  32'(bus.gnt),     'h00);
        check("single_idle_d",    32'(bus.d),       'h00);
        check("single_idle_ptr",  32'(bus.dbg.ptr), 4);

        // Fairness with all eight requesting
        do_reset();
        bus.req   = 8'hFF;
        bus.ready = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            #1;
            check("fair_a",     32'(bus.a),       (k / 4) % 8);
            check("fair_gnt",   32'(bus.gnt),     1 << ((k / 4) % 8));
            check("fair_cnt",   32'(bus.dbg.cnt), k % 4);
            check("fair_valid", 32'(bus.valid),   1);
            check("fair_d",     32'(bus.d),       cval[(k / 4) % 8]);
        end

        // Stall on requester 1
        do_reset();
        bus.req   = 8'h02;
        bus.ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            #1;
            check("stall_gnt",   32'(bus.gnt),     'h02);
            check("stall_cnt",   32'(bus.dbg.cnt), 0);
            check("stall_valid", 32'(bus.valid),   1);
        end
        bus.ready = 1'b1;
        #1;
        check("stall_go_cnt", 32'(bus.dbg.cnt), 0);
        for (int j = 1; j < 6; j++) begin
            @(negedge clk);
            #1;
            check("stall_go_gnt", 32'(bus.gnt),     'h02);
            check("stall_go_cnt", 32'(bus.dbg.cnt), j % 4);
        end

        // Early drop: owner 2 drops after two beats, requester 5 pending
        do_reset();
        bus.req   = 8'h24;
        bus.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("drop_a",   32'(bus.a),       2);
            check("drop_cnt", 32'(bus.dbg.cnt), k);
        end
        bus.req = 8'h20;
        #1;
        check("drop_valid_now", 32'(bus.valid), 0);
        @(negedge clk);
        #1;
        check("drop_gnt",   32'(bus.gnt),     'h20);
        check("drop_a5",    32'(bus.a),       5);
        check("drop_cnt0",  32'(bus.dbg.cnt), 0);
        check("drop_ptr",   32'(bus.dbg.ptr), 3);
        check("drop_valid", 32'(bus.valid),   1);
        check("drop_d",     32'(bus.d),       'hF5);

        // Asynchronous reset during owner-6 beat 2
        do_reset();
        bus.req   = 8'h40;
        bus.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("mid_a",   32'(bus.a),       6);
            check("mid_cnt", 32'(bus.dbg.cnt), k);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_gnt",   32'(bus.gnt),     'h00);
        check("mid_rst_valid", 32'(bus.valid),   0);
        check("mid_rst_busy",  32'(bus.busy),    0);
        check("mid_rst_d",     32'(bus.d),       'h00);
        check("mid_rst_cnt",   32'(bus.dbg.cnt), 0);
        @(negedge clk);
        bus.req = 8'h41;
        rst     = 1'b0;
        @(negedge clk);
        #1;
        check("mid_regrant_gnt", 32'(bus.gnt),     'h01);
        check("mid_regrant_a",   32'(bus.a),       0);
        check("mid_regrant_cnt", 32'(bus.dbg.cnt), 0);
        check("mid_regrant_d",   32'(bus.d),       'hA0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
